// File: rtl/data_mem_access.sv
// ----------------------------------------------------------------------------
// data_mem_access
//
// Bridges a MEM-stage load/store onto a variable-latency, word-addressed,
// byte-enabled data-memory handshake. While a request is outstanding the
// pipeline is stalled. The returned word, the load mode and the low address
// bits are registered for the WB-stage load extender. Misaligned accesses are
// retired immediately without a request. Requests that are never acknowledged
// are aborted after TIMEOUT cycles.
//
// Parameters
//   TIMEOUT             wait cycles before an unacknowledged request is
//                       aborted (1..255)
//
// Ports
//   clk                 clock, rising edge
//   rst_n               asynchronous active-low reset
//   MemReqValid         MEM stage holds a valid instruction
//   RegWriteM[2:0]      load mode (NOREGWRITE, LB, LH, LW, LBU, LHU)
//   StoreTypeM[1:0]     00 none, 01 SB, 10 SH, 11 SW
//   AluOutM[31:0]       byte address
//   StoreDataM[31:0]    store data, right-aligned
//   StallMem            combinational pipeline freeze (IF..MEM)
//   DmReq               memory request
//   DmWe                1 = write
//   DmAddr[29:0]        word address
//   DmBe[3:0]           byte enables
//   DmWData[31:0]       write data
//   DmAck               request completed this cycle
//   DmRData[31:0]       read word, valid with DmAck
//   LoadWordW[31:0]     word to the load extender
//   LoadedBytesSelectW  low address bits of the retired access
//   RegWriteW[2:0]      load mode of the retired access
//   ValidW              pulse: an access retired
//   MisalignW           pulse with ValidW: misaligned, not issued
//   TimeoutW            pulse with ValidW: aborted after TIMEOUT cycles
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; MEM-stage instruction is evaluated
// WAIT  | request on the bus, waiting for DmAck or the timeout
// ----------------------------------------------------------------------------
module data_mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReqValid,
    input  logic [2:0]  RegWriteM,
    input  logic [1:0]  StoreTypeM,
    input  logic [31:0] AluOutM,
    input  logic [31:0] StoreDataM,
    output logic        StallMem,
    output logic        DmReq,
    output logic        DmWe,
    output logic [29:0] DmAddr,
    output logic [3:0]  DmBe,
    output logic [31:0] DmWData,
    input  logic        DmAck,
    input  logic [31:0] DmRData,
    output logic [31:0] LoadWordW,
    output logic [1:0]  LoadedBytesSelectW,
    output logic [2:0]  RegWriteW,
    output logic        ValidW,
    output logic        MisalignW,
    output logic        TimeoutW
);

    // Load-mode encodings shared with the rest of the pipeline.
    localparam logic [2:0] MODE_NONE = 3'd0;
    localparam logic [2:0] MODE_LB   = 3'd1;
    localparam logic [2:0] MODE_LH   = 3'd2;
    localparam logic [2:0] MODE_LW   = 3'd3;
    localparam logic [2:0] MODE_LBU  = 3'd4;
    localparam logic [2:0] MODE_LHU  = 3'd5;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    // Terminal count: the last waiting cycle before the abort.
    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state, state_nx;

    logic        is_store;
    logic        is_load_mode;
    logic        mem_op;
    logic        aligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [2:0]  req_mode;

    logic [7:0]  wait_cnt;
    logic        wait_tc;

    logic [2:0]  lat_mode;
    logic [1:0]  lat_lbs;

    logic        issue;
    logic        retire_ack;
    logic        retire_to;
    logic        retire_mis;
    logic        stall_int;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign is_store     = (StoreTypeM != ST_NONE);
    assign is_load_mode = (RegWriteM inside {MODE_LB, MODE_LH, MODE_LW, MODE_LBU, MODE_LHU});
    assign mem_op       = MemReqValid && (is_store || is_load_mode);

    // A store overrides any load mode presented in the same cycle.
    assign req_mode = is_store ? MODE_NONE : RegWriteM;

    always_comb begin
        aligned = 1'b1;
        if (is_store) begin
            case (StoreTypeM)
                ST_SH:   aligned = ~AluOutM[0];
                ST_SW:   aligned = (AluOutM[1:0] == 2'b00);
                default: aligned = 1'b1;
            endcase
        end else begin
            case (RegWriteM)
                MODE_LH, MODE_LHU: aligned = ~AluOutM[0];
                MODE_LW:           aligned = (AluOutM[1:0] == 2'b00);
                default:           aligned = 1'b1;
            endcase
        end
    end

    // Sub-word stores replicate the data across the word so the byte
    // enables alone select the lane.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = 32'h0;
        case (StoreTypeM)
            ST_SB: begin
                req_be    = 4'b0001 << AluOutM[1:0];
                req_wdata = {4{StoreDataM[7:0]}};
            end
            ST_SH: begin
                req_be    = 4'b0011 << {AluOutM[1], 1'b0};
                req_wdata = {2{StoreDataM[15:0]}};
            end
            ST_SW: begin
                req_be    = 4'b1111;
                req_wdata = StoreDataM;
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = 32'h0;
            end
        endcase
    end

    assign wait_tc = (wait_cnt == TIMEOUT_TC);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (mem_op && aligned) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (DmAck || wait_tc) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        issue      = 1'b0;
        retire_ack = 1'b0;
        retire_to  = 1'b0;
        retire_mis = 1'b0;
        stall_int  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op) begin
                    if (aligned) begin
                        issue     = 1'b1;
                        stall_int = 1'b1;
                    end else begin
                        retire_mis = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // An ack in the terminal-count cycle still completes normally.
                if (DmAck) begin
                    retire_ack = 1'b1;
                end else if (wait_tc) begin
                    retire_to = 1'b1;
                end else begin
                    stall_int = 1'b1;
                end
            end
            default: begin
                stall_int = 1'b0;
            end
        endcase
    end

    // Gated by reset so the pipeline is never frozen while held in reset.
    assign StallMem = rst_n && stall_int;

    // ------------------------------------------------------------------
    // Memory-side request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DmReq   <= 1'b0;
            DmWe    <= 1'b0;
            DmAddr  <= 30'h0;
            DmBe    <= 4'h0;
            DmWData <= 32'h0;
        end else if (issue) begin
            DmReq   <= 1'b1;
            DmWe    <= is_store;
            DmAddr  <= AluOutM[31:2];
            DmBe    <= req_be;
            DmWData <= req_wdata;
        end else if (retire_ack || retire_to) begin
            DmReq   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_mode <= MODE_NONE;
            lat_lbs  <= 2'b00;
        end else if (issue) begin
            lat_mode <= req_mode;
            lat_lbs  <= AluOutM[1:0];
        end
    end

    // Saturating wait counter: never wraps back onto the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'h00;
        end else if (issue) begin
            wait_cnt <= 8'h00;
        end else if ((state == S_WAIT) && !DmAck && (wait_cnt != 8'hFF)) begin
            wait_cnt <= wait_cnt + 8'h01;
        end
    end

    // ------------------------------------------------------------------
    // WB-side registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidW    <= 1'b0;
            MisalignW <= 1'b0;
            TimeoutW  <= 1'b0;
        end else begin
            ValidW    <= retire_ack || retire_to || retire_mis;
            MisalignW <= retire_mis;
            TimeoutW  <= retire_to;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LoadWordW          <= 32'h0;
            LoadedBytesSelectW <= 2'b00;
            RegWriteW          <= MODE_NONE;
        end else if (retire_ack) begin
            LoadWordW          <= (lat_mode != MODE_NONE) ? DmRData : 32'h0;
            LoadedBytesSelectW <= lat_lbs;
            RegWriteW          <= lat_mode;
        end else if (retire_to) begin
            LoadWordW          <= 32'h0;
            LoadedBytesSelectW <= lat_lbs;
            RegWriteW          <= MODE_NONE;
        end else if (retire_mis) begin
            LoadWordW          <= 32'h0;
            LoadedBytesSelectW <= AluOutM[1:0];
            RegWriteW          <= MODE_NONE;
        end else begin
            // Nothing retires: no register write, word and byte select hold.
            RegWriteW          <= MODE_NONE;
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
module tb_data_mem_access;

    localparam int TO = 4;

    localparam logic [2:0] M_NONE = 3'd0;
    localparam logic [2:0] M_LB   = 3'd1;
    localparam logic [2:0] M_LH   = 3'd2;
    localparam logic [2:0] M_LW   = 3'd3;
    localparam logic [2:0] M_LBU  = 3'd4;
    localparam logic [2:0] M_LHU  = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemReqValid = 1'b0;
    logic [2:0]  RegWriteM = 3'd0;
    logic [1:0]  StoreTypeM = 2'd0;
    logic [31:0] AluOutM = 32'h0;
    logic [31:0] StoreDataM = 32'h0;
    logic        StallMem;
    logic        DmReq;
    logic        DmWe;
    logic [29:0] DmAddr;
    logic [3:0]  DmBe;
    logic [31:0] DmWData;
    logic        DmAck = 1'b0;
    logic [31:0] DmRData = 32'h0;
    logic [31:0] LoadWordW;
    logic [1:0]  LoadedBytesSelectW;
    logic [2:0]  RegWriteW;
    logic        ValidW;
    logic        MisalignW;
    logic        TimeoutW;

    data_mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReqValid(MemReqValid), .RegWriteM(RegWriteM), .StoreTypeM(StoreTypeM),
        .AluOutM(AluOutM), .StoreDataM(StoreDataM), .StallMem(StallMem),
        .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmBe(DmBe), .DmWData(DmWData),
        .DmAck(DmAck), .DmRData(DmRData), .LoadWordW(LoadWordW),
        .LoadedBytesSelectW(LoadedBytesSelectW), .RegWriteW(RegWriteW),
        .ValidW(ValidW), .MisalignW(MisalignW), .TimeoutW(TimeoutW)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: access-level view of the block.
    // busy/age describe an outstanding access and how many cycles it has
    // waited; the e_* values are what the outputs must show.
    // ------------------------------------------------------------------
    bit          m_busy = 0;
    int          m_age  = 0;
    logic [2:0]  m_mode = M_NONE;
    logic [1:0]  m_lbs  = 2'b00;

    logic        e_req = 0, e_we = 0, e_valid = 0, e_mis = 0, e_to = 0;
    logic [29:0] e_addr = 0;
    logic [3:0]  e_be = 0;
    logic [31:0] e_wdata = 0, e_lw = 0;
    logic [1:0]  e_lbs = 0;
    logic [2:0]  e_rw = M_NONE;

    // Access size in bytes, 0 when the instruction does not touch memory.
    function automatic int acc_size(input logic [1:0] st, input logic [2:0] rw);
        if (st == 2'd1) return 1;
        if (st == 2'd2) return 2;
        if (st == 2'd3) return 4;
        if (rw == M_LB || rw == M_LBU) return 1;
        if (rw == M_LH || rw == M_LHU) return 2;
        if (rw == M_LW) return 4;
        return 0;
    endfunction

    function automatic bit model_stall();
        int sz;
        if (!rst_n) return 0;
        if (m_busy) return !DmAck && (m_age + 1 != TO);
        sz = MemReqValid ? acc_size(StoreTypeM, RegWriteM) : 0;
        return (sz != 0) && ((int'(AluOutM[1:0]) % sz) == 0);
    endfunction

    always @(negedge rst_n) begin
        m_busy = 0; m_age = 0; m_mode = M_NONE; m_lbs = 0;
        e_req = 0; e_we = 0; e_valid = 0; e_mis = 0; e_to = 0;
        e_addr = 0; e_be = 0; e_wdata = 0; e_lw = 0; e_lbs = 0; e_rw = M_NONE;
    end

    always @(posedge clk) begin
        int sz;
        int a;
        if (rst_n) begin
            e_valid = 0; e_mis = 0; e_to = 0;
            if (!m_busy) begin
                sz = MemReqValid ? acc_size(StoreTypeM, RegWriteM) : 0;
                a  = int'(AluOutM[1:0]);
                if (sz == 0) begin
                    e_rw = M_NONE;
                end else if (a % sz != 0) begin
                    e_valid = 1; e_mis = 1; e_rw = M_NONE; e_lw = 0; e_lbs = AluOutM[1:0];
                end else begin
                    m_busy = 1; m_age = 0;
                    m_mode = (StoreTypeM != 0) ? M_NONE : RegWriteM;
                    m_lbs  = AluOutM[1:0];
                    e_req  = 1;
                    e_we   = (StoreTypeM != 0);
                    e_addr = AluOutM[31:2];
                    if (StoreTypeM != 0) begin
                        e_be = 4'(((1 << sz) - 1) << a);
                        for (int i = 0; i < 4; i++)
                            e_wdata[8*i +: 8] = StoreDataM[8*(i % sz) +: 8];
                    end else begin
                        e_be = 4'hF;
                    end
                    e_rw = M_NONE;
                end
            end else if (DmAck) begin
                e_valid = 1; e_req = 0; m_busy = 0;
                e_lw  = (m_mode != M_NONE) ? DmRData : 32'h0;
                e_rw  = m_mode;
                e_lbs = m_lbs;
            end else if (m_age + 1 == TO) begin
                e_valid = 1; e_to = 1; e_req = 0; m_busy = 0;
                e_lw = 0; e_rw = M_NONE; e_lbs = m_lbs;
            end else begin
                m_age++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("StallMem", 32'(StallMem), 32'(model_stall()));
        chk("DmReq", 32'(DmReq), 32'(e_req));
        chk("ValidW", 32'(ValidW), 32'(e_valid));
        chk("MisalignW", 32'(MisalignW), 32'(e_mis));
        chk("TimeoutW", 32'(TimeoutW), 32'(e_to));
        chk("RegWriteW", 32'(RegWriteW), 32'(e_rw));
        chk("LoadWordW", LoadWordW, e_lw);
        chk("LoadedBytesSelectW", 32'(LoadedBytesSelectW), 32'(e_lbs));
        if (e_req) begin
            chk("DmWe", 32'(DmWe), 32'(e_we));
            chk("DmAddr", 32'(DmAddr), 32'(e_addr));
            chk("DmBe", 32'(DmBe), 32'(e_be));
            if (e_we) chk("DmWData", DmWData, e_wdata);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    logic        cap_req, cap_we;
    logic [29:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    int          stalls;

    // ack_at: cycle (counting the issue cycle as 0) in which DmAck is
    // driven; -1 = never; 0 = no wait at all (misaligned / non-memory op).
    task automatic access(input logic [2:0] rw, input logic [1:0] st,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input int ack_at, input logic [31:0] rd);
        int last;
        last = (ack_at < 0) ? TO : ack_at;
        stalls = 0;
        @(posedge clk); #1;
        MemReqValid = 1; RegWriteM = rw; StoreTypeM = st; AluOutM = addr; StoreDataM = sd; DmAck = 0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                DmAck   = (c == ack_at);
                DmRData = (c == ack_at) ? rd : (32'hBAD0_0000 | 32'(c));
            end
            @(negedge clk);
            if (StallMem) stalls++;
            if (c == ((last > 0) ? 1 : 0)) begin
                cap_req = DmReq; cap_we = DmWe; cap_addr = DmAddr; cap_be = DmBe; cap_wdata = DmWData;
            end
        end
        @(posedge clk); #1;
        MemReqValid = 0; RegWriteM = M_NONE; StoreTypeM = 0; DmAck = 0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset StallMem", 32'(StallMem), 32'h0);
        chk("reset DmReq", 32'(DmReq), 32'h0);
        chk("reset RegWriteW", 32'(RegWriteW), 32'(M_NONE));
        chk("reset LoadWordW", LoadWordW, 32'h0);
        #10 rst_n = 1;

        // Aligned LW, ack in cycle 3.
        access(M_LW, 2'd0, 32'h0000_1008, 32'h0, 3, 32'hDEAD_BEEF);
        chk("lw stalls", 32'(stalls), 32'd3);
        chk("lw DmReq", 32'(cap_req), 32'h1);
        chk("lw DmAddr", 32'(cap_addr), 32'h402);
        chk("lw DmBe", 32'(cap_be), 32'hF);
        chk("lw DmWe", 32'(cap_we), 32'h0);
        chk("lw ValidW", 32'(ValidW), 32'h1);
        chk("lw LoadWordW", LoadWordW, 32'hDEAD_BEEF);
        chk("lw RegWriteW", 32'(RegWriteW), 32'(M_LW));
        chk("lw LBS", 32'(LoadedBytesSelectW), 32'h0);

        // SB at byte 3, ack as soon as the request is visible.
        access(M_NONE, 2'd1, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0);
        chk("sb stalls", 32'(stalls), 32'd1);
        chk("sb DmWe", 32'(cap_we), 32'h1);
        chk("sb DmBe", 32'(cap_be), 32'b1000);
        chk("sb DmWData", cap_wdata, 32'hA5A5_A5A5);
        chk("sb ValidW", 32'(ValidW), 32'h1);
        chk("sb RegWriteW", 32'(RegWriteW), 32'(M_NONE));

        // SH at byte 2, then misaligned LHU.
        access(M_NONE, 2'd2, 32'h0000_0102, 32'h0000_1234, 2, 32'h0);
        chk("sh DmBe", 32'(cap_be), 32'b1100);
        chk("sh DmWData", cap_wdata, 32'h1234_1234);
        access(M_LHU, 2'd0, 32'h0000_0101, 32'h0, 0, 32'h0);
        chk("lhu stalls", 32'(stalls), 32'd0);
        chk("lhu DmReq", 32'(cap_req), 32'h0);
        chk("lhu MisalignW", 32'(MisalignW), 32'h1);
        chk("lhu ValidW", 32'(ValidW), 32'h1);

        // Valid instruction that is not a memory op.
        access(M_NONE, 2'd0, 32'h0000_0200, 32'h0, 0, 32'h0);
        chk("nop stalls", 32'(stalls), 32'd0);
        chk("nop ValidW", 32'(ValidW), 32'h0);

        // LB never acknowledged.
        access(M_LB, 2'd0, 32'h0000_0200, 32'h0, -1, 32'h0);
        chk("to stalls", 32'(stalls), 32'd4);
        chk("to TimeoutW", 32'(TimeoutW), 32'h1);
        chk("to ValidW", 32'(ValidW), 32'h1);
        chk("to DmReq", 32'(DmReq), 32'h0);
        chk("to LoadWordW", LoadWordW, 32'h0);

        // LBU at byte 2.
        access(M_LBU, 2'd0, 32'h0000_0022, 32'h0, 1, 32'h1122_3344);
        chk("lbu LoadWordW", LoadWordW, 32'h1122_3344);
        chk("lbu RegWriteW", 32'(RegWriteW), 32'(M_LBU));
        chk("lbu LBS", 32'(LoadedBytesSelectW), 32'h2);

        // Reset in WAIT; the ack arrives in the following cycle.
        @(posedge clk); #1;
        MemReqValid = 1; RegWriteM = M_LW; StoreTypeM = 0; AluOutM = 32'h0000_0040;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst DmReq before", 32'(DmReq), 32'h1);
        #1 rst_n = 0;
        #1;
        chk("rst DmReq async", 32'(DmReq), 32'h0);
        chk("rst StallMem", 32'(StallMem), 32'h0);
        #1;
        MemReqValid = 0; RegWriteM = M_NONE; rst_n = 1; DmAck = 1; DmRData = 32'h5555_5555;
        @(posedge clk); #1;
        DmAck = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst ValidW", 32'(ValidW), 32'h0);
            chk("rst LoadWordW", LoadWordW, 32'h0);
            chk("rst DmReq", 32'(DmReq), 32'h0);
        end

        // SW and LW in the same cycle: the store wins.
        access(M_LW, 2'd3, 32'h0000_0040, 32'hCAFE_F00D, 1, 32'h7777_7777);
        chk("sw DmWe", 32'(cap_we), 32'h1);
        chk("sw DmBe", 32'(cap_be), 32'hF);
        chk("sw DmWData", cap_wdata, 32'hCAFE_F00D);
        chk("sw ValidW", 32'(ValidW), 32'h1);
        chk("sw RegWriteW", 32'(RegWriteW), 32'(M_NONE));
        chk("sw LoadWordW", LoadWordW, 32'h0);

        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
